// File: rtl/display_arbiter.sv
// Shares one 5x7 column-scan displayer between requesters A and B. Images are
// held for a minimum number of frames and swapped only on frame boundaries.
module display_arbiter #(
    parameter int DATA_WIDTH    = 35,
    parameter int TOTAL_COLUNES = 5,
    parameter int HOLD_FRAMES   = 4,
    parameter int FRAME_CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_a,
    input  logic [DATA_WIDTH-1:0] image_a,
    input  logic                  req_b,
    input  logic [DATA_WIDTH-1:0] image_b,
    input  logic                  blank_req,
    output logic                  grant_a,
    output logic                  grant_b,
    output logic [DATA_WIDTH-1:0] image_out,
    output logic                  display_enable,
    output logic                  frame_start,
    output logic                  owner
);

    localparam int COL_W = (TOTAL_COLUNES > 1) ? $clog2(TOTAL_COLUNES) : 1;
    localparam logic [COL_W-1:0]       COL_LAST   = COL_W'(TOTAL_COLUNES - 1);
    localparam logic [FRAME_CNT_W-1:0] HOLD_LAST  = FRAME_CNT_W'(HOLD_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] FRAME_MAX  = {FRAME_CNT_W{1'b1}};

    // IDLE: display off; SHOW: minimum hold running; HOLD: minimum met, waiting
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [COL_W-1:0]        col_cnt_q, col_cnt_d;
    logic [FRAME_CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [DATA_WIDTH-1:0]   image_q, image_d;
    logic                    owner_q, owner_d;
    logic                    last_owner_q, last_owner_d;
    logic                    grant_a_q, grant_a_d;
    logic                    grant_b_q, grant_b_d;

    logic boundary;
    logic any_req;
    logic pick_b;
    logic do_grant;

    assign boundary = (state_q != IDLE) && (col_cnt_q == COL_LAST);
    assign any_req  = req_a | req_b;
    // On a tie the requester that did not own the display last time wins.
    assign pick_b   = req_b & (~req_a | ~last_owner_q);

    always_comb begin
        state_d      = state_q;
        col_cnt_d    = col_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        image_d      = image_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant_a_d    = 1'b0;
        grant_b_d    = 1'b0;
        do_grant     = 1'b0;

        case (state_q)
            IDLE: begin
                col_cnt_d   = '0;
                frame_cnt_d = '0;
                do_grant    = any_req;
            end
            SHOW, HOLD: begin
                col_cnt_d = boundary ? '0 : col_cnt_q + 1'b1;
                if (boundary) begin
                    if (frame_cnt_q != FRAME_MAX) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                    if ((state_q == HOLD) || (frame_cnt_q == HOLD_LAST)) begin
                        if (blank_req) begin
                            state_d = IDLE;
                        end else if (any_req) begin
                            do_grant = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_grant) begin
            state_d      = SHOW;
            image_d      = pick_b ? image_b : image_a;
            owner_d      = pick_b;
            last_owner_d = pick_b;
            grant_a_d    = ~pick_b;
            grant_b_d    = pick_b;
            col_cnt_d    = '0;
            frame_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            col_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            image_q      <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            grant_a_q    <= 1'b0;
            grant_b_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_cnt_q    <= col_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            image_q      <= image_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            grant_a_q    <= grant_a_d;
            grant_b_q    <= grant_b_d;
        end
    end

    assign display_enable = (state_q != IDLE);
    assign frame_start    = display_enable && (col_cnt_q == '0);
    assign image_out      = image_q;
    assign owner          = owner_q;
    assign grant_a        = grant_a_q;
    assign grant_b        = grant_b_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: a per-cycle vector table for reset and the
// first grant, then hand-written sequences for hold, arbitration, blank and reset.
module tb_display_arbiter;

    localparam int DW = 35;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_a, req_b, blank_req;
    logic [DW-1:0] image_a, image_b;
    logic          grant_a, grant_b, display_enable, frame_start, owner;
    logic [DW-1:0] image_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    localparam logic [DW-1:0] IMG_A = 35'h1_2345_6789;
    localparam logic [DW-1:0] IMG_B = 35'h6_5A5A_0F0F;

    display_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req_a          (req_a),
        .image_a        (image_a),
        .req_b          (req_b),
        .image_b        (image_b),
        .blank_req      (blank_req),
        .grant_a        (grant_a),
        .grant_b        (grant_b),
        .image_out      (image_out),
        .display_enable (display_enable),
        .frame_start    (frame_start),
        .owner          (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          ra;
        logic          rb;
        logic          blk;
        logic [DW-1:0] ia;
        logic [DW-1:0] ib;
        logic          e_ga;
        logic          e_gb;
        logic          e_de;
        logic          e_fs;
        logic          e_own;
        logic [DW-1:0] e_img;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0; req_a = 1'b0; req_b = 1'b0; blank_req = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic chk_outputs(input string tag, input logic ga, input logic gb, input logic de,
                               input logic fs, input logic own, input logic [DW-1:0] img);
        chk({tag, ".grant_a"}, DW'(grant_a), DW'(ga));
        chk({tag, ".grant_b"}, DW'(grant_b), DW'(gb));
        chk({tag, ".display_enable"}, DW'(display_enable), DW'(de));
        chk({tag, ".frame_start"}, DW'(frame_start), DW'(fs));
        chk({tag, ".owner"}, DW'(owner), DW'(own));
        chk({tag, ".image_out"}, image_out, img);
    endtask

    initial begin
        reset = 1'b0; req_a = 1'b0; req_b = 1'b0; blank_req = 1'b0;
        image_a = IMG_A; image_b = IMG_B;

        // rst ra rb blk ia ib | ga gb de fs own img
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, IMG_A, IMG_B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, IMG_A, IMG_B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, IMG_A, IMG_B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, IMG_A, IMG_B, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, IMG_A};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, IMG_A, IMG_B, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, IMG_A};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, '0,    IMG_B, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, IMG_A};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, '0,    IMG_B, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, IMG_A};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, '0,    IMG_B, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, IMG_A};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, '0,    IMG_B, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, IMG_A};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, '0,    IMG_B, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, IMG_A};

        // Reset, idle with blank (ignored), first grant and frame_start cadence
        for (int i = 0; i < 10; i++) begin
            reset = vecs[i].rst; req_a = vecs[i].ra; req_b = vecs[i].rb;
            blank_req = vecs[i].blk; image_a = vecs[i].ia; image_b = vecs[i].ib;
            step();
            chk_outputs($sformatf("vec%0d", i), vecs[i].e_ga, vecs[i].e_gb, vecs[i].e_de,
                        vecs[i].e_fs, vecs[i].e_own, vecs[i].e_img);
        end

        // B requests during A's minimum hold; served exactly 20 clocks after grant_a
        image_a = IMG_A; image_b = IMG_B;
        do_reset();
        req_a = 1'b1;
        step();
        cyc = 0;
        chk("t3.grant_a", DW'(grant_a), DW'(1'b1));
        req_a = 1'b0;
        step();
        req_b = 1'b1;
        for (int k = 2; k <= 20; k++) begin
            step();
            if (k < 20) begin
                chk("t3.grant_b_early", DW'(grant_b), DW'(1'b0));
                chk("t3.image_hold", image_out, IMG_A);
                chk("t3.frame_start", DW'(frame_start), DW'((k % 5) == 0));
            end else begin
                chk("t3.grant_b", DW'(grant_b), DW'(1'b1));
                chk("t3.owner", DW'(owner), DW'(1'b1));
                chk("t3.image_b", image_out, IMG_B);
                chk("t3.enable", DW'(display_enable), DW'(1'b1));
            end
        end
        req_b = 1'b0;

        // Both requesters held continuously: grants alternate A,B,A,B
        do_reset();
        req_a = 1'b1; req_b = 1'b1;
        step();
        cyc = 0;
        chk("t4.first_grant_a", DW'(grant_a), DW'(1'b1));
        chk("t4.first_grant_b", DW'(grant_b), DW'(1'b0));
        for (int k = 1; k <= 80; k++) begin
            step();
            chk("t4.grant_a", DW'(grant_a), DW'((k % 40) == 0));
            chk("t4.grant_b", DW'(grant_b), DW'((k % 40) == 20));
            chk("t4.owner", DW'(owner), DW'(((k / 20) % 2) == 1));
            chk("t4.image", image_out, (((k / 20) % 2) == 1) ? IMG_B : IMG_A);
            chk("t4.enable", DW'(display_enable), DW'(1'b1));
        end
        req_a = 1'b0; req_b = 1'b0;

        // Blank requested mid-frame in HOLD: drops only after the boundary, reqs ignored
        do_reset();
        req_a = 1'b1;
        step();
        cyc = 0;
        req_a = 1'b0;
        while (cyc < 22) step();
        chk("t5.hold_enable", DW'(display_enable), DW'(1'b1));
        blank_req = 1'b1; req_b = 1'b1;
        step();
        chk("t5.enable_c23", DW'(display_enable), DW'(1'b1));
        step();
        chk("t5.enable_c24", DW'(display_enable), DW'(1'b1));
        chk("t5.no_grant_c24", DW'(grant_b), DW'(1'b0));
        step();
        chk_outputs("t5.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IMG_A);
        step();
        chk("t5.idle_grant_b", DW'(grant_b), DW'(1'b1));
        chk("t5.idle_owner", DW'(owner), DW'(1'b1));
        chk("t5.idle_enable", DW'(display_enable), DW'(1'b1));
        blank_req = 1'b0; req_b = 1'b0;

        // Reset at col_cnt=3 in SHOW with req_b pending: no grant_b survives
        do_reset();
        req_a = 1'b1;
        step();
        cyc = 0;
        req_a = 1'b0; req_b = 1'b1;
        step(); step(); step();
        chk("t6.pre_enable", DW'(display_enable), DW'(1'b1));
        reset = 1'b0;
        step();
        chk_outputs("t6.reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        reset = 1'b1;
        step();
        chk_outputs("t6.after", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, IMG_B);
        req_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
